// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared widths, reset constants and next-PC select encoding
package instr_fetch_unit_pkg;

   localparam int                WORD_W          = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR_DEF   = 32'h0000_0000;
   localparam logic [WORD_W-1:0] RESET_PC_DEF    = 32'd0;
   localparam int                IMEM_DEPTH_DEF  = 256;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_HOLD   = 2'd1,
      PC_JUMP   = 2'd2,
      PC_BRANCH = 2'd3
   } pc_sel_e;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] pc_next;
      logic              valid;
   } ifid_t;

   // EX branch beats everything; an ID jump only counts when the ID stage is not stalled.
   function automatic pc_sel_e pick_pc_sel(input logic ex_valid,
                                           input logic id_valid,
                                           input logic stall);
      pc_sel_e sel;
      if (ex_valid)
         sel = PC_BRANCH;
      else if (id_valid && !stall)
         sel = PC_JUMP;
      else if (stall)
         sel = PC_HOLD;
      else
         sel = PC_SEQ;
      return sel;
   endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// rtl/ifid_pipe_reg.sv - IF/ID pipeline register with squash (priority) and hold controls
module ifid_pipe_reg
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              squash,
   input  logic              hold,
   input  logic [WORD_W-1:0] d_instr,
   input  logic [WORD_W-1:0] d_pc,
   input  logic [WORD_W-1:0] d_pc_next,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc,
   output logic [WORD_W-1:0] ifid_pc_next,
   output logic              ifid_valid
);

   ifid_t ifid_d;
   ifid_t ifid_q;

   // Squash keeps the address fields; they are meaningless once valid drops.
   always_comb begin
      ifid_d = ifid_q;
      if (squash) begin
         ifid_d.valid = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end else if (!hold) begin
         ifid_d.valid   = 1'b1;
         ifid_d.instr   = d_instr;
         ifid_d.pc      = d_pc;
         ifid_d.pc_next = d_pc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_q.valid   <= 1'b0;
         ifid_q.instr   <= NOP_INSTR;
         ifid_q.pc      <= '0;
         ifid_q.pc_next <= '0;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid_instr   = ifid_q.instr;
   assign ifid_pc      = ifid_q.pc;
   assign ifid_pc_next = ifid_q.pc_next;
   assign ifid_valid   = ifid_q.valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, next-PC mux, ROM request, fault flag and fetch counter
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int                IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              redir_id_valid,
   input  logic [WORD_W-1:0] redir_id_target,
   input  logic              redir_ex_valid,
   input  logic [WORD_W-1:0] redir_ex_target,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_instr,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc,
   output logic [WORD_W-1:0] ifid_pc_next,
   output logic              ifid_valid,
   output logic              fetch_fault,
   output logic [WORD_W-1:0] fetch_count
);

   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(IMEM_DEPTH);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic              fault_q, fault_d;
   logic [WORD_W-1:0] count_q, count_d;

   pc_sel_e           pc_sel;
   logic [WORD_W-1:0] pc_plus1;
   logic              out_of_range;
   logic              squash;
   logic              fault_now;
   logic              load;

   always_comb begin
      pc_sel       = pick_pc_sel(redir_ex_valid, redir_id_valid, stall);
      pc_plus1     = pc_q + WORD_W'(1);
      out_of_range = (pc_q >= DEPTH_W);

      // A taken jump means the word at PC is on the wrong path (no delay slot).
      squash    = redir_ex_valid | flush | (pc_sel == PC_JUMP);
      fault_now = !squash && !stall && out_of_range;
      load      = !squash && !stall && !out_of_range;

      case (pc_sel)
         PC_BRANCH: pc_d = redir_ex_target;
         PC_JUMP:   pc_d = redir_id_target;
         PC_HOLD:   pc_d = pc_q;
         default:   pc_d = pc_plus1;
      endcase

      fault_d = fault_q | fault_now;

      count_d = count_q;
      if (load && (count_q != '1))
         count_d = count_q + WORD_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   ifid_pipe_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk          (clk),
      .rst_n        (rst_n),
      .squash       (squash | fault_now),
      .hold         (stall),
      .d_instr      (imem_instr),
      .d_pc         (pc_q),
      .d_pc_next    (pc_plus1),
      .ifid_instr   (ifid_instr),
      .ifid_pc      (ifid_pc),
      .ifid_pc_next (ifid_pc_next),
      .ifid_valid   (ifid_valid)
   );

   assign imem_addr   = pc_q;
   assign fetch_fault = fault_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a behavioural fetch model
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        redir_id_valid, redir_ex_valid;
   logic [31:0] redir_id_target, redir_ex_target;
   logic [31:0] imem_addr, imem_instr;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc_next, fetch_count;
   logic        ifid_valid, fetch_fault;

   logic [31:0] rom [0:255];

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m_pc, m_instr, m_ifpc, m_ifpcn, m_count;
   logic        m_valid, m_fault;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .flush           (flush),
      .redir_id_valid  (redir_id_valid),
      .redir_id_target (redir_id_target),
      .redir_ex_valid  (redir_ex_valid),
      .redir_ex_target (redir_ex_target),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .ifid_instr      (ifid_instr),
      .ifid_pc         (ifid_pc),
      .ifid_pc_next    (ifid_pc_next),
      .ifid_valid      (ifid_valid),
      .fetch_fault     (fetch_fault),
      .fetch_count     (fetch_count)
   );

   assign imem_instr = (imem_addr < 32'd256) ? rom[imem_addr[7:0]] : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {31'b0, act}, {31'b0, exp});
   endtask

   // Reference model: squash/hold/fetch decisions taken straight from the priority rules.
   task automatic model_reset();
      m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0;
      m_ifpc = 32'd0; m_ifpcn = 32'd0; m_fault = 1'b0; m_count = 32'd0;
   endtask

   task automatic model_squash();
      m_valid = 1'b0; m_instr = 32'd0;
   endtask

   task automatic model_step();
      if (redir_ex_valid) begin
         model_squash();
         m_pc = redir_ex_target;
      end else if (redir_id_valid && !stall) begin
         model_squash();
         m_pc = redir_id_target;
      end else begin
         if (flush) begin
            model_squash();
         end else if (!stall) begin
            if (m_pc >= 32'd256) begin
               model_squash();
               m_fault = 1'b1;
            end else begin
               m_instr = rom[m_pc[7:0]];
               m_ifpc  = m_pc;
               m_ifpcn = m_pc + 32'd1;
               m_valid = 1'b1;
               if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end
         end
         if (!stall) m_pc = m_pc + 32'd1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      chk("imem_addr", imem_addr, m_pc);
      chk1("ifid_valid", ifid_valid, m_valid);
      chk("ifid_instr", ifid_instr, m_instr);
      if (m_valid) begin
         chk("ifid_pc", ifid_pc, m_ifpc);
         chk("ifid_pc_next", ifid_pc_next, m_ifpcn);
      end
      chk1("fetch_fault", fetch_fault, m_fault);
      chk("fetch_count", fetch_count, m_count);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      stall = 1'b0; flush = 1'b0;
      redir_id_valid = 1'b0; redir_id_target = 32'd0;
      redir_ex_valid = 1'b0; redir_ex_target = 32'd0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_addr"}, imem_addr, 32'd0);
      chk1({tag, "_valid"}, ifid_valid, 1'b0);
      chk({tag, "_instr"}, ifid_instr, 32'd0);
      chk({tag, "_pc"}, ifid_pc, 32'd0);
      chk({tag, "_pcn"}, ifid_pc_next, 32'd0);
      chk1({tag, "_fault"}, fetch_fault, 1'b0);
      chk({tag, "_count"}, fetch_count, 32'd0);
   endtask

   function automatic logic [31:0] rand_target();
      if ($urandom_range(0, 9) == 0) return 32'($urandom_range(250, 270));
      return 32'($urandom_range(0, 20));
   endfunction

   initial begin
      logic [31:0] cnt_snap;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rom[0]  = 32'h2802_0005; rom[1]  = 32'h2804_0003; rom[2]  = 32'h0006_1100;
      rom[3]  = 32'h0808_1100; rom[4]  = 32'h480A_300F; rom[5]  = 32'h0C0E_2000;
      rom[6]  = 32'h2810_000A; rom[7]  = 32'h3C12_0004; rom[8]  = 32'h0014_1900;
      rom[9]  = 32'h5016_0002; rom[10] = 32'h2802_0001; rom[11] = 32'h0404_1000;
      rom[12] = 32'h1006_FFFE; rom[13] = 32'h4400_0000; rom[14] = 32'h2816_000B;
      rom[15] = 32'h2818_0009;

      rst_n = 1'b0;
      clear_in();
      repeat (2) cyc();
      chk_reset_outputs("rst");
      rst_n = 1'b1;

      cyc();
      chk("t1_pc0", ifid_pc, 32'd0);
      chk("t1_instr0", ifid_instr, 32'h2802_0005);
      chk1("t1_valid0", ifid_valid, 1'b1);
      cyc();
      chk("t1_pc1", ifid_pc, 32'd1);
      chk("t1_instr1", ifid_instr, 32'h2804_0003);
      chk("t1_pcn1", ifid_pc_next, 32'd2);

      cyc();
      cnt_snap = fetch_count;
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("t2_hold_instr", ifid_instr, 32'h0006_1100);
         chk("t2_hold_addr", imem_addr, 32'd3);
      end
      stall = 1'b0;
      cyc();
      chk("t2_pc3", ifid_pc, 32'd3);
      chk("t2_instr3", ifid_instr, 32'h0808_1100);
      chk("t2_count", fetch_count, cnt_snap + 32'd1);

      repeat (9) cyc();
      chk("t3_addr13", imem_addr, 32'd13);
      redir_id_valid = 1'b1; redir_id_target = 32'd15;
      cyc();
      chk1("t3_valid", ifid_valid, 1'b0);
      chk("t3_addr15", imem_addr, 32'd15);
      clear_in();
      cyc();
      chk("t3_pc15", ifid_pc, 32'd15);
      chk("t3_instr15", ifid_instr, 32'h2818_0009);

      redir_ex_valid = 1'b1; redir_ex_target = 32'd4;
      redir_id_valid = 1'b1; redir_id_target = 32'd15;
      stall = 1'b1;
      cyc();
      chk("t4_addr4", imem_addr, 32'd4);
      chk1("t4_valid", ifid_valid, 1'b0);
      clear_in();
      cyc();
      chk("t4_instr", ifid_instr, 32'h480A_300F);

      cnt_snap = fetch_count;
      redir_ex_valid = 1'b1; redir_ex_target = 32'd300;
      cyc();
      clear_in();
      cyc();
      chk1("t5_valid", ifid_valid, 1'b0);
      chk("t5_instr", ifid_instr, 32'd0);
      chk1("t5_fault", fetch_fault, 1'b1);
      chk("t5_count", fetch_count, cnt_snap);
      redir_ex_valid = 1'b1; redir_ex_target = 32'd0;
      cyc();
      clear_in();
      cyc();
      chk1("t5_fault_sticky", fetch_fault, 1'b1);
      chk("t5_instr0", ifid_instr, 32'h2802_0005);

      redir_ex_valid = 1'b1; redir_ex_target = 32'd9;
      cyc();
      clear_in();
      chk("t6_addr9", imem_addr, 32'd9);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("t6");
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("t6_pc0", ifid_pc, 32'd0);
      chk1("t6_valid", ifid_valid, 1'b1);

      redir_ex_valid = 1'b1; redir_ex_target = 32'hFFFF_FFFF;
      cyc();
      clear_in();
      chk("wrap_addr_max", imem_addr, 32'hFFFF_FFFF);
      cyc();
      chk("wrap_addr0", imem_addr, 32'd0);
      chk1("wrap_fault", fetch_fault, 1'b1);

      flush = 1'b1; stall = 1'b1;
      cyc();
      chk("fs_addr_hold", imem_addr, 32'd0);
      chk1("fs_valid", ifid_valid, 1'b0);
      clear_in();
      cyc();
      chk("fs_instr", ifid_instr, 32'h2802_0005);

      for (int c = 0; c < 3000; c++) begin
         stall           = ($urandom_range(0, 99) < 25);
         flush           = ($urandom_range(0, 99) < 10);
         redir_id_valid  = ($urandom_range(0, 99) < 10);
         redir_id_target = rand_target();
         redir_ex_valid  = ($urandom_range(0, 99) < 8);
         redir_ex_target = rand_target();
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk1("rnd_rst_valid", ifid_valid, 1'b0);
            cyc();
            rst_n = 1'b1;
         end
         cyc();
      end

      clear_in();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
